// File: rtl/cp0_pkg.sv
// ============================================================================
// Module : cp0_pkg
// Brief  : CP0 register numbers, exception codes, field positions, reset values
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_COUNT    = 5'd9,
        CP0_COMPARE  = 5'd11,
        CP0_STATUS   = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14,
        CP0_PRID     = 5'd15,
        CP0_CONFIG   = 5'd16
    } cp0_reg_e;

    // Classifier excepttype codes
    localparam logic [31:0] c_et_none = 32'h0000_0000;
    localparam logic [31:0] c_et_int  = 32'h0000_0001;
    localparam logic [31:0] c_et_adel = 32'h0000_0004;
    localparam logic [31:0] c_et_ades = 32'h0000_0005;
    localparam logic [31:0] c_et_sys  = 32'h0000_0008;
    localparam logic [31:0] c_et_bp   = 32'h0000_0009;
    localparam logic [31:0] c_et_ri   = 32'h0000_000A;
    localparam logic [31:0] c_et_ov   = 32'h0000_000C;
    localparam logic [31:0] c_et_eret = 32'h0000_000E;

    localparam logic [4:0]  c_exccode_int = 5'h00;

    // Status / Cause field positions
    localparam int c_st_ie     = 0;
    localparam int c_st_exl    = 1;
    localparam int c_ca_bd     = 31;
    localparam int c_ca_ti     = 30;
    localparam int c_ca_ip_lo  = 8;
    localparam int c_ca_exc_lo = 2;

    localparam logic [31:0] c_status_rst   = 32'h0040_0000;
    localparam logic [31:0] c_status_wmask = 32'h0000_FF03;

    // Interrupts report ExcCode 0 although the classifier tags them with 01
    function automatic logic [4:0] exccode_of(input logic [31:0] et);
        return (et == c_et_int) ? c_exccode_int : et[4:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module : cp0_timer
// Brief  : Count/Compare timer, Count advancing every second cycle
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;
    logic        w_match;

    assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick      <= 1'b0;
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_timer_int <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (i_count_we) begin
                r_count <= i_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
            if (i_compare_we) begin
                r_compare <= i_wdata;
            end
            // Writing Compare is the only acknowledge of a pending timer
            if (i_compare_we) begin
                r_timer_int <= 1'b0;
            end else if (w_match) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;

endmodule

`default_nettype wire

// File: rtl/cp0_regfile.sv
// ============================================================================
// Module : cp0_regfile
// Brief  : MIPS CP0 register file: exception capture, eret, timer, mfc0/mtc0
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] PRID_VAL   = 32'h0042_8000,
    parameter logic [31:0] CONFIG_VAL = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    logic [31:0] r_status;
    logic        r_cause_bd;
    logic [7:0]  r_cause_ip;
    logic [4:0]  r_cause_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_exc;
    logic        w_eret;
    logic        w_addr_exc;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_int;
    logic [31:0] w_cause;
    logic [31:0] w_exc_epc;

    assign w_wr_count   = we_i && (waddr_i == CP0_COUNT);
    assign w_wr_compare = we_i && (waddr_i == CP0_COMPARE);
    assign w_wr_status  = we_i && (waddr_i == CP0_STATUS);
    assign w_wr_cause   = we_i && (waddr_i == CP0_CAUSE);
    assign w_wr_epc     = we_i && (waddr_i == CP0_EPC);

    assign w_eret     = (excepttype_i == c_et_eret);
    assign w_exc      = (excepttype_i != c_et_none) && !w_eret;
    assign w_addr_exc = (excepttype_i == c_et_adel) || (excepttype_i == c_et_ades);
    assign w_exc_epc  = in_delayslot_i ? (pc_i - 32'd4) : pc_i;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_we   (w_wr_count),
        .i_compare_we (w_wr_compare),
        .i_wdata      (wdata_i),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_timer_int  (w_timer_int)
    );

    // mtc0 updates come first so the exception/eret assignments below override them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_status        <= c_status_rst;
            r_cause_bd      <= 1'b0;
            r_cause_ip      <= 8'd0;
            r_cause_exccode <= 5'd0;
            r_epc           <= 32'd0;
            r_badvaddr      <= 32'd0;
        end else begin
            r_cause_ip[7:2] <= {int_i[5] | w_timer_int, int_i[4:0]};
            if (w_wr_cause) begin
                r_cause_ip[1:0] <= wdata_i[9:8];
            end
            if (w_wr_status) begin
                r_status <= (r_status & ~c_status_wmask) | (wdata_i & c_status_wmask);
            end
            if (w_wr_epc) begin
                r_epc <= wdata_i;
            end
            if (w_exc) begin
                r_status[c_st_exl] <= 1'b1;
                r_cause_exccode    <= exccode_of(excepttype_i);
                // Nested exceptions keep the original return point
                if (!r_status[c_st_exl]) begin
                    r_epc      <= w_exc_epc;
                    r_cause_bd <= in_delayslot_i;
                end
                if (w_addr_exc) begin
                    r_badvaddr <= bad_addr_i;
                end
            end else if (w_eret) begin
                r_status[c_st_exl] <= 1'b0;
            end
        end
    end

    assign w_cause = {r_cause_bd, w_timer_int, 14'd0, r_cause_ip, 1'b0,
                      r_cause_exccode, 2'b00};

    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = r_badvaddr;
            CP0_COUNT:    rdata_o = w_count;
            CP0_COMPARE:  rdata_o = w_compare;
            CP0_STATUS:   rdata_o = r_status;
            CP0_CAUSE:    rdata_o = w_cause;
            CP0_EPC:      rdata_o = r_epc;
            CP0_PRID:     rdata_o = PRID_VAL;
            CP0_CONFIG:   rdata_o = CONFIG_VAL;
            default:      rdata_o = 32'd0;
        endcase
    end

    // eret forwards a same-cycle mtc0 to EPC so the redirect sees the new value
    always_comb begin
        newpc_o = 32'd0;
        if (w_exc) begin
            newpc_o = EXC_VECTOR;
        end else if (w_eret) begin
            newpc_o = w_wr_epc ? wdata_i : r_epc;
        end
    end

    assign flush_o     = |excepttype_i;
    assign status_o    = r_status;
    assign cause_o     = w_cause;
    assign epc_o       = r_epc;
    assign badvaddr_o  = r_badvaddr;
    assign timer_int_o = w_timer_int;

endmodule

`default_nettype wire

// File: tb/tb_cp0_regfile.sv
// ============================================================================
// Module : tb_cp0_regfile
// Brief  : Directed bench for cp0_regfile with a behavioural CP0 model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = 5'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [4:0]  raddr_i = 5'd0;
    logic [5:0]  int_i = 6'd0;
    logic [31:0] excepttype_i = 32'd0;
    logic [31:0] pc_i = 32'd0;
    logic        in_delayslot_i = 1'b0;
    logic [31:0] bad_addr_i = 32'd0;
    logic [31:0] rdata_o, status_o, cause_o, epc_o, badvaddr_o, newpc_o;
    logic        timer_int_o, flush_o;

    int n_checks = 0;
    int n_errors = 0;
    bit en_cmp   = 1'b0;
    bit auto_rd  = 1'b0;
    int ridx     = 0;
    logic [4:0] rlist [11] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14,
                               5'd15, 5'd16, 5'd0, 5'd3, 5'd31};

    cp0_regfile dut (
        .clk            (clk),
        .resetn         (resetn),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .int_i          (int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .bad_addr_i     (bad_addr_i),
        .rdata_o        (rdata_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .badvaddr_o     (badvaddr_o),
        .timer_int_o    (timer_int_o),
        .flush_o        (flush_o),
        .newpc_o        (newpc_o)
    );

    always #5 clk = ~clk;

    // Architectural model state
    bit          m_tick, m_timer, m_bd;
    logic [31:0] m_count, m_compare, m_status, m_epc, m_bad;
    logic [7:0]  m_ip;
    logic [4:0]  m_code;

    function automatic logic [31:0] m_cause();
        return {m_bd, m_timer, 14'd0, m_ip, 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'h0042_8000;
            5'd16:   return 32'h8000_0000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_newpc();
        if (excepttype_i == 32'd0) return 32'd0;
        if (excepttype_i != 32'hE) return 32'hBFC0_0380;
        return (we_i && waddr_i == 5'd14) ? wdata_i : m_epc;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tick = 0; m_timer = 0; m_bd = 0;
            m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
            m_epc = 0; m_bad = 0; m_ip = 0; m_code = 0;
        end else begin
            automatic bit          old_tick  = m_tick;
            automatic bit          old_timer = m_timer;
            automatic bit          old_exl   = m_status[1];
            automatic logic [31:0] old_count = m_count;
            automatic logic [31:0] old_cmp   = m_compare;
            automatic logic [31:0] et        = excepttype_i;
            automatic bit          exc       = (et != 0) && (et != 32'hE);
            if (we_i) begin
                case (waddr_i)
                    5'd9:  m_count   = wdata_i;
                    5'd11: m_compare = wdata_i;
                    5'd12: m_status  = {16'h0040, wdata_i[15:8], 6'd0, wdata_i[1:0]};
                    5'd13: m_ip[1:0] = wdata_i[9:8];
                    5'd14: m_epc     = wdata_i;
                    default: ;
                endcase
            end
            if (!(we_i && waddr_i == 5'd9) && old_tick) m_count = old_count + 1;
            if (we_i && waddr_i == 5'd11) m_timer = 0;
            else if (old_count == old_cmp && old_cmp != 0) m_timer = 1;
            m_ip[7:2] = {int_i[5] | old_timer, int_i[4:0]};
            if (exc) begin
                m_status[1] = 1'b1;
                m_code = (et == 32'h1) ? 5'd0 : et[4:0];
                if (!old_exl) begin
                    m_epc = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    m_bd  = in_delayslot_i;
                end
                if (et == 32'h4 || et == 32'h5) m_bad = bad_addr_i;
            end else if (et == 32'hE) begin
                m_status[1] = 1'b0;
            end
            m_tick = !old_tick;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en_cmp && resetn) begin
            chk("status", status_o, m_status);
            chk("cause", cause_o, m_cause());
            chk("epc", epc_o, m_epc);
            chk("badvaddr", badvaddr_o, m_bad);
            chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
            chk("rdata", rdata_o, m_read(raddr_i));
            chk("flush", {31'd0, flush_o}, {31'd0, excepttype_i != 0});
            chk("newpc", newpc_o, m_newpc());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        we_i = 1'b0;
        excepttype_i = 32'd0;
        if (auto_rd) begin
            raddr_i = rlist[ridx];
            ridx = (ridx + 1) % 11;
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        #1;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'd0);
        chk("rst_epc", epc_o, 32'd0);
        chk("rst_bad", badvaddr_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_timer", {31'd0, timer_int_o}, 32'd0);
        resetn = 1'b1;
        step();
        en_cmp = 1'b1;
        auto_rd = 1'b1;

        // Count/Compare timer
        mtc0(5'd9, 32'd0);   step();
        mtc0(5'd11, 32'd10); step();
        for (int i = 0; i < 60 && !timer_int_o; i++) step();
        chk("timer_set", {31'd0, timer_int_o}, 32'd1);
        step(); #1;
        chk("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
        chk("cause_ti", {31'd0, cause_o[30]}, 32'd1);
        mtc0(5'd11, 32'd50); step(); #1;
        chk("timer_clear", {31'd0, timer_int_o}, 32'd0);

        // Hardware interrupt sampling, software IP, ignored writes
        int_i = 6'b010101; step(); step(); #1;
        chk("cause_ip_hw", {26'd0, cause_o[15:10]}, 32'h15);
        int_i = 6'd0;
        mtc0(5'd13, 32'h0000_0300); step(); #1;
        chk("cause_ip_sw", {30'd0, cause_o[9:8]}, 32'd3);
        mtc0(5'd8, 32'hDEAD_BEEF); step();
        mtc0(5'd15, 32'h1111_1111); step(); #1;
        chk("bad_ro", badvaddr_o, 32'd0);

        // Syscall, not in delay slot
        excepttype_i = 32'h8; pc_i = 32'hBFC0_0100; in_delayslot_i = 1'b0; #1;
        chk("sys_flush", {31'd0, flush_o}, 32'd1);
        chk("sys_newpc", newpc_o, 32'hBFC0_0380);
        step(); #1;
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_code", {27'd0, cause_o[6:2]}, 32'd8);
        chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
        excepttype_i = 32'hE; #1;
        chk("eret_newpc", newpc_o, 32'hBFC0_0100);
        step(); #1;
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

        // AdEL in delay slot
        excepttype_i = 32'h4; pc_i = 32'h8000_1004; in_delayslot_i = 1'b1;
        bad_addr_i = 32'h8000_2001;
        step(); #1;
        chk("adel_epc", epc_o, 32'h8000_1000);
        chk("adel_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("adel_bad", badvaddr_o, 32'h8000_2001);

        // Nested overflow, then eret with same-cycle EPC write
        excepttype_i = 32'hC; pc_i = 32'h9000_0000; in_delayslot_i = 1'b0;
        bad_addr_i = 32'h0;
        step(); #1;
        chk("nest_epc", epc_o, 32'h8000_1000);
        chk("nest_code", {27'd0, cause_o[6:2]}, 32'h0C);
        chk("nest_bad", badvaddr_o, 32'h8000_2001);
        excepttype_i = 32'hE; mtc0(5'd14, 32'h0000_1234); #1;
        chk("eret_fwd", newpc_o, 32'h0000_1234);
        step(); #1;
        chk("eret2_exl", {31'd0, status_o[1]}, 32'd0);
        chk("eret2_epc", epc_o, 32'h0000_1234);

        // Interrupt colliding with mtc0 Status
        mtc0(5'd12, 32'h0000_FF01); step(); #1;
        chk("st_write", status_o, 32'h0040_FF01);
        excepttype_i = 32'h1; mtc0(5'd12, 32'h0); step(); #1;
        chk("int_status", status_o, 32'h0040_0002);
        chk("int_code", {27'd0, cause_o[6:2]}, 32'd0);

        // Count wrap
        auto_rd = 1'b0; raddr_i = 5'd9;
        mtc0(5'd9, 32'hFFFF_FFFE); step();
        for (int i = 0; i < 10 && rdata_o != 32'd0; i++) step();
        #1;
        chk("count_wrap", rdata_o, 32'd0);
        auto_rd = 1'b1;

        // Pending timer lost on mid-operation reset
        mtc0(5'd9, 32'd5);  step();
        mtc0(5'd11, 32'd6); step();
        for (int i = 0; i < 20 && !timer_int_o; i++) step();
        chk("timer_set2", {31'd0, timer_int_o}, 32'd1);
        @(posedge clk); #3;
        resetn = 1'b0; #1;
        chk("mrst_timer", {31'd0, timer_int_o}, 32'd0);
        chk("mrst_status", status_o, 32'h0040_0000);
        chk("mrst_epc", epc_o, 32'd0);
        chk("mrst_cause", cause_o, 32'd0);
        step(); step();
        resetn = 1'b1;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
